// File: rtl/save_transfer.sv
// Moves byte-wide save-RAM reads and writes onto the banked cartridge bus. The bank register
// is rewritten only when the bank changes. One further request can wait in a pending slot.
module save_transfer #(
  parameter int          BANK_ADDR_BITS = 13,
  parameter int          BANK_COUNT     = 16,
  parameter int          RD_DELAY       = 15,
  parameter int          WR_DELAY       = 63,
  parameter logic [15:0] SRAM_BASE      = 16'hA000,
  parameter logic [15:0] BANK_REG       = 16'h4000,
  parameter logic [7:0]  CAMERA_BANK    = 8'h10
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        bridge_rd,
  input  logic        bridge_wr,
  input  logic [31:0] bridge_8bit_addr,
  input  logic [7:0]  bridge_8bit_wr_data,
  output logic [7:0]  bridge_8bit_rd_data,
  input  logic        disable_camera,
  output logic        busy,
  output logic [15:0] cart_address,
  output logic [7:4]  cart_tran_bank0_out,
  input  logic [7:0]  cart_tran_bank1_in,
  output logic [7:0]  cart_tran_bank1_out,
  output logic        cart_tran_bank1_dir
);
  localparam int AW = BANK_ADDR_BITS + 8;

  typedef enum logic [2:0] {
    IDLE, BANK_WR, BANK_REL, ACCESS, ACC_REL, CAM_BANK, CAM_WR, CAM_REL
  } state_t;
  typedef enum logic [1:0] {K_RD, K_WR, K_CAM} kind_t;

  state_t        state_reg, state_next;
  logic [15:0]   cnt_reg, limit;
  logic          rd_prev_reg, wr_prev_reg, cam_prev_reg;
  logic          rd_rise, wr_rise, cam_rise, new_valid;
  kind_t         new_kind;
  kind_t         req_kind_reg, pend_kind_reg, start_kind;
  logic [AW-1:0] req_addr_reg, pend_addr_reg, start_addr;
  logic [7:0]    req_data_reg, pend_data_reg, start_data;
  logic [7:0]    req_bank_reg, start_bank;
  logic          pend_valid_reg, start_valid, start_oor;
  logic          done, take;
  logic [7:0]    current_bank_reg, rd_data_reg;
  logic          bank_valid_reg;
  logic [15:0]   sram_addr;
  logic          cart_read, cart_write, cart_dir;
  logic [7:0]    data_out;
  logic          unused_addr_bits;

  assign unused_addr_bits = &{1'b0, bridge_8bit_addr[31:AW]};

  assign rd_rise   = bridge_rd & ~rd_prev_reg;
  assign wr_rise   = bridge_wr & ~wr_prev_reg;
  assign cam_rise  = disable_camera & ~cam_prev_reg;
  assign new_valid = rd_rise | wr_rise | cam_rise;
  assign new_kind  = rd_rise ? K_RD : (wr_rise ? K_WR : K_CAM);
  assign sram_addr = SRAM_BASE + 16'(req_addr_reg[BANK_ADDR_BITS-1:0]);

  always_comb begin
    limit = '0;
    case (state_reg)
      BANK_WR, CAM_BANK, CAM_WR: limit = 16'(WR_DELAY);
      ACCESS:  limit = (req_kind_reg == K_RD) ? 16'(RD_DELAY) : 16'(WR_DELAY);
      default: limit = '0;
    endcase
    done = (cnt_reg == limit);
    // A request may start from IDLE or on the last cycle of a completing release.
    take = (state_reg == IDLE) || (done && (state_reg == ACC_REL || state_reg == CAM_REL));

    start_valid = pend_valid_reg | new_valid;
    start_kind  = pend_valid_reg ? pend_kind_reg : new_kind;
    start_addr  = pend_valid_reg ? pend_addr_reg : bridge_8bit_addr[AW-1:0];
    start_data  = pend_valid_reg ? pend_data_reg : bridge_8bit_wr_data;
    start_bank  = (start_kind == K_CAM) ? CAMERA_BANK : start_addr[BANK_ADDR_BITS +: 8];
    start_oor   = (start_kind != K_CAM) && (32'(start_bank) >= BANK_COUNT);

    state_next = state_reg;
    if (take) begin
      if (!start_valid)                 state_next = IDLE;
      else if (start_kind == K_CAM)     state_next = CAM_BANK;
      else if (start_oor)               state_next = ACC_REL;
      else if (!bank_valid_reg || start_bank != current_bank_reg) state_next = BANK_WR;
      else                              state_next = ACCESS;
    end else if (done) begin
      case (state_reg)
        BANK_WR, CAM_BANK: state_next = BANK_REL;
        BANK_REL:          state_next = (req_kind_reg == K_CAM) ? CAM_WR : ACCESS;
        ACCESS:            state_next = ACC_REL;
        CAM_WR:            state_next = CAM_REL;
        default:           state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_reg        <= IDLE;
      cnt_reg          <= '0;
      rd_prev_reg      <= 1'b0;
      wr_prev_reg      <= 1'b0;
      cam_prev_reg     <= 1'b0;
      req_kind_reg     <= K_RD;
      req_addr_reg     <= '0;
      req_data_reg     <= '0;
      req_bank_reg     <= '0;
      pend_valid_reg   <= 1'b0;
      pend_kind_reg    <= K_RD;
      pend_addr_reg    <= '0;
      pend_data_reg    <= '0;
      current_bank_reg <= '0;
      bank_valid_reg   <= 1'b0;
      rd_data_reg      <= '0;
    end else begin
      state_reg    <= state_next;
      rd_prev_reg  <= bridge_rd;
      wr_prev_reg  <= bridge_wr;
      cam_prev_reg <= disable_camera;
      cnt_reg      <= (take || done) ? '0 : cnt_reg + 16'd1;
      if (take) begin
        if (start_valid) begin
          req_kind_reg <= start_kind;
          req_addr_reg <= start_addr;
          req_data_reg <= start_data;
          req_bank_reg <= start_bank;
          if (start_oor && start_kind == K_RD) rd_data_reg <= 8'hFF;
        end
        // The pending entry was just consumed, so a same-cycle edge may take its place.
        if (pend_valid_reg) begin
          pend_valid_reg <= new_valid;
          pend_kind_reg  <= new_kind;
          pend_addr_reg  <= bridge_8bit_addr[AW-1:0];
          pend_data_reg  <= bridge_8bit_wr_data;
        end
      end else if (new_valid && !pend_valid_reg) begin
        pend_valid_reg <= 1'b1;
        pend_kind_reg  <= new_kind;
        pend_addr_reg  <= bridge_8bit_addr[AW-1:0];
        pend_data_reg  <= bridge_8bit_wr_data;
      end
      if (state_reg == ACCESS && req_kind_reg == K_RD && done) rd_data_reg <= cart_tran_bank1_in;
      if (state_reg == BANK_REL) begin
        current_bank_reg <= req_bank_reg;
        bank_valid_reg   <= 1'b1;
      end
    end
  end

  always_comb begin
    cart_read    = 1'b0;
    cart_write   = 1'b0;
    cart_dir     = 1'b0;
    data_out     = '0;
    cart_address = '0;
    case (state_reg)
      BANK_WR, CAM_BANK: begin
        cart_write   = 1'b1;
        cart_dir     = 1'b1;
        cart_address = BANK_REG;
        data_out     = req_bank_reg;
      end
      BANK_REL: cart_address = BANK_REG;
      ACCESS: begin
        cart_address = sram_addr;
        if (req_kind_reg == K_RD) begin
          cart_read = 1'b1;
        end else begin
          cart_write = 1'b1;
          cart_dir   = 1'b1;
          data_out   = req_data_reg;
        end
      end
      ACC_REL: cart_address = sram_addr;
      CAM_WR: begin
        cart_write   = 1'b1;
        cart_dir     = 1'b1;
        cart_address = SRAM_BASE;
      end
      CAM_REL: cart_address = SRAM_BASE;
      default: ;
    endcase
  end

  assign cart_tran_bank0_out = {1'b0, ~cart_write, ~cart_read, cart_write};
  assign cart_tran_bank1_out = data_out;
  assign cart_tran_bank1_dir = cart_dir;
  assign bridge_8bit_rd_data = rd_data_reg;
  assign busy                = (state_reg != IDLE) || pend_valid_reg;
endmodule

// File: tb/tb_save_transfer.sv
// Bench for save_transfer: random and table-driven requests are checked against a model that
// lists the expected cart bus cycles.
module tb_save_transfer;
  logic        clk_sys = 1'b0, reset = 1'b1;
  logic        bridge_rd = 1'b0, bridge_wr = 1'b0, disable_camera = 1'b0;
  logic [31:0] bridge_8bit_addr = '0;
  logic [7:0]  bridge_8bit_wr_data = '0, bridge_8bit_rd_data;
  logic        busy;
  logic [15:0] cart_address;
  logic [7:4]  cart_tran_bank0_out;
  logic [7:0]  cart_tran_bank1_in = '0, cart_tran_bank1_out;
  logic        cart_tran_bank1_dir;

  always #5 clk_sys = ~clk_sys;

  save_transfer dut (
    .clk_sys(clk_sys), .reset(reset), .bridge_rd(bridge_rd), .bridge_wr(bridge_wr),
    .bridge_8bit_addr(bridge_8bit_addr), .bridge_8bit_wr_data(bridge_8bit_wr_data),
    .bridge_8bit_rd_data(bridge_8bit_rd_data), .disable_camera(disable_camera), .busy(busy),
    .cart_address(cart_address), .cart_tran_bank0_out(cart_tran_bank0_out),
    .cart_tran_bank1_in(cart_tran_bank1_in), .cart_tran_bank1_out(cart_tran_bank1_out),
    .cart_tran_bank1_dir(cart_tran_bank1_dir)
  );

  typedef struct {
    bit          is_wr;
    logic [15:0] addr;
    logic [7:0]  data;
    int          len;
    int          start;
  } seg_t;

  int   checks = 0, passes = 0, cyc = 0;
  bit   started = 0, seg_open = 0;
  seg_t cur;
  seg_t obs_q[$];
  seg_t exp_q[$];

  // Reference state: the bank the cart should currently have selected, and the expected read byte.
  bit         m_bv = 0;
  int         m_bank = 0;
  logic [7:0] exp_rd = 8'h00;

  logic cart_wr, cart_rd;
  assign cart_wr = cart_tran_bank0_out[4];
  assign cart_rd = ~cart_tran_bank0_out[5];

  always @(posedge clk_sys) cyc++;

  always @(negedge clk_sys) begin
    if (started) begin
      checks++;
      if ((cart_rd && cart_wr) || cart_tran_bank1_dir !== cart_wr || cart_tran_bank0_out[7] !== 1'b0 ||
          cart_tran_bank0_out[6] !== ~cart_wr)
        $display("FAIL bus_rules cyc=%0d: got ctl=%b dir=%b required rd/wr exclusive, dir==wr, ctl[7:6]={0,~wr}",
                 cyc, cart_tran_bank0_out, cart_tran_bank1_dir);
      else passes++;
      if (cart_rd || cart_wr) begin
        if (seg_open && cur.is_wr == cart_wr && cur.addr === cart_address &&
            cur.data === (cart_wr ? cart_tran_bank1_out : 8'h00)) begin
          cur.len++;
        end else begin
          if (seg_open) obs_q.push_back(cur);
          cur = '{cart_wr, cart_address, (cart_wr ? cart_tran_bank1_out : 8'h00), 1, cyc};
          seg_open = 1;
        end
      end else if (seg_open) begin
        obs_q.push_back(cur);
        seg_open = 0;
      end
    end
  end

  // kind: 0 read, 1 write, 2 camera disable
  task automatic model_req(input int kind, input logic [31:0] addr, input logic [7:0] data,
                           input logic [7:0] cin);
    int bank = int'((addr >> 13) & 32'hFF);
    int off  = int'(addr & 32'h1FFF);
    if (kind == 2) begin
      exp_q.push_back('{1'b1, 16'h4000, 8'h10, 64, 0});
      exp_q.push_back('{1'b1, 16'hA000, 8'h00, 64, 0});
      m_bv = 1;
      m_bank = 16;
    end else if (bank >= 16) begin
      if (kind == 0) exp_rd = 8'hFF;
    end else begin
      if (!m_bv || bank != m_bank) begin
        exp_q.push_back('{1'b1, 16'h4000, 8'(bank), 64, 0});
        m_bv = 1;
        m_bank = bank;
      end
      if (kind == 0) begin
        exp_q.push_back('{1'b0, 16'(32'hA000 + off), 8'h00, 16, 0});
        exp_rd = cin;
      end else begin
        exp_q.push_back('{1'b1, 16'(32'hA000 + off), data, 64, 0});
      end
    end
  endtask

  task automatic send(input int kind, input logic [31:0] addr, input logic [7:0] data);
    @(posedge clk_sys); #1;
    bridge_8bit_addr = addr;
    bridge_8bit_wr_data = data;
    case (kind)
      0:       bridge_rd = 1'b1;
      1:       bridge_wr = 1'b1;
      default: disable_camera = 1'b1;
    endcase
    @(posedge clk_sys); #1;
    bridge_rd = 1'b0;
    bridge_wr = 1'b0;
    disable_camera = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (4) @(posedge clk_sys);
    #1;
    started = 1;
    checks++;
    if (busy !== 1'b0 || cart_address !== 16'h0000 || cart_tran_bank0_out !== 4'b0110 ||
        cart_tran_bank1_dir !== 1'b0 || cart_tran_bank1_out !== 8'h00 || bridge_8bit_rd_data !== 8'h00)
      $display("FAIL reset_state: got busy=%b addr=%h ctl=%b dir=%b out=%h rd=%h required 0/0000/0110/0/00/00",
               busy, cart_address, cart_tran_bank0_out, cart_tran_bank1_dir, cart_tran_bank1_out,
               bridge_8bit_rd_data);
    else passes++;
    reset = 1'b0;
    m_bv = 0;
    exp_rd = 8'h00;
  endtask

  task automatic test_transactions(input bit directed, input int n);
    for (int i = 0; i < n; i++) begin
      int kind, bank, waited;
      logic [31:0] addr;
      logic [7:0] data, cin;
      data = 8'($urandom());
      cin  = 8'($urandom());
      if (directed && i < 6) begin
        case (i)
          0: begin kind = 0; addr = 32'h0000_2005; cin = 8'h5A; end
          1: begin kind = 0; addr = 32'h0000_2006; end
          2: begin kind = 1; addr = 32'h0000_3FFF; data = 8'hC3; end
          3: begin kind = 0; addr = 32'h0002_0000; end
          4: begin kind = 2; addr = 32'h0; end
          default: begin kind = 0; addr = 32'h0000_2010; end
        endcase
      end else begin
        int r = int'($urandom_range(0, 9));
        kind = (r < 4) ? 0 : ((r < 8) ? 1 : 2);
        bank = ($urandom_range(0, 5) == 0) ? int'($urandom_range(16, 255)) : int'($urandom_range(0, 2));
        addr = ($urandom() & 32'hFFE0_0000) | (32'(bank) << 13) | ($urandom() & 32'h1FFF);
      end
      cart_tran_bank1_in = cin;
      obs_q.delete();
      exp_q.delete();
      model_req(kind, addr, data, cin);
      send(kind, addr, data);
      checks++;
      if (busy !== 1'b1) $display("FAIL txn%0d busy_rise: got %b required 1", i, busy);
      else passes++;
      waited = 0;
      while (busy === 1'b1 && waited < 400) begin
        @(negedge clk_sys);
        waited++;
      end
      checks++;
      if (busy !== 1'b0) $display("FAIL txn%0d busy_fall: got %b required 0 within 400 cycles", i, busy);
      else passes++;
      repeat (2) @(negedge clk_sys);
      checks++;
      if (obs_q.size() != exp_q.size())
        $display("FAIL txn%0d seg_count kind=%0d addr=%h: got %0d required %0d", i, kind, addr,
                 obs_q.size(), exp_q.size());
      else passes++;
      for (int k = 0; k < exp_q.size() && k < obs_q.size(); k++) begin
        checks++;
        if (obs_q[k].is_wr != exp_q[k].is_wr || obs_q[k].addr !== exp_q[k].addr ||
            obs_q[k].data !== exp_q[k].data || obs_q[k].len != exp_q[k].len)
          $display("FAIL txn%0d seg%0d: got wr=%0b addr=%h data=%h len=%0d required wr=%0b addr=%h data=%h len=%0d",
                   i, k, obs_q[k].is_wr, obs_q[k].addr, obs_q[k].data, obs_q[k].len,
                   exp_q[k].is_wr, exp_q[k].addr, exp_q[k].data, exp_q[k].len);
        else passes++;
      end
      checks++;
      if (bridge_8bit_rd_data !== exp_rd)
        $display("FAIL txn%0d rd_data: got %h required %h", i, bridge_8bit_rd_data, exp_rd);
      else passes++;
    end
  endtask

  task automatic test_pending();
    int waited, n;
    logic [7:0] cin = 8'($urandom());
    cart_tran_bank1_in = cin;
    obs_q.delete();
    exp_q.delete();
    model_req(0, 32'h0000_4011, 8'h00, cin);
    model_req(0, 32'h0000_4022, 8'h00, cin);
    send(0, 32'h0000_4011, 8'h00);
    @(posedge clk_sys);
    send(0, 32'h0000_4022, 8'h00);
    send(0, 32'h0000_4033, 8'h00);
    waited = 0;
    while (busy === 1'b1 && waited < 400) begin
      @(negedge clk_sys);
      waited++;
    end
    checks++;
    if (busy !== 1'b0) $display("FAIL pending busy_fall: got %b required 0 within 400 cycles", busy);
    else passes++;
    repeat (2) @(negedge clk_sys);
    n = obs_q.size();
    checks++;
    if (n != exp_q.size()) $display("FAIL pending seg_count: got %0d required %0d", n, exp_q.size());
    else passes++;
    for (int k = 0; k < exp_q.size() && k < n; k++) begin
      checks++;
      if (obs_q[k].is_wr != exp_q[k].is_wr || obs_q[k].addr !== exp_q[k].addr || obs_q[k].len != exp_q[k].len)
        $display("FAIL pending seg%0d: got wr=%0b addr=%h len=%0d required wr=%0b addr=%h len=%0d", k,
                 obs_q[k].is_wr, obs_q[k].addr, obs_q[k].len, exp_q[k].is_wr, exp_q[k].addr, exp_q[k].len);
      else passes++;
    end
    if (n >= 2) begin
      checks++;
      if (obs_q[n-1].start != obs_q[n-2].start + obs_q[n-2].len + 1)
        $display("FAIL pending back_to_back: got second start %0d required %0d", obs_q[n-1].start,
                 obs_q[n-2].start + obs_q[n-2].len + 1);
      else passes++;
    end
    checks++;
    if (bridge_8bit_rd_data !== exp_rd)
      $display("FAIL pending rd_data: got %h required %h", bridge_8bit_rd_data, exp_rd);
    else passes++;
  endtask

  task automatic test_reset_mid();
    int waited = 0;
    send(0, 32'h0000_4100, 8'h00);
    while (!cart_rd && waited < 200) begin
      @(negedge clk_sys);
      waited++;
    end
    checks++;
    if (cart_rd !== 1'b1) $display("FAIL reset_mid reach_access: got cart_read=%b required 1", cart_rd);
    else passes++;
    repeat (3) @(negedge clk_sys);
    @(posedge clk_sys); #1;
    reset = 1'b1;
    @(posedge clk_sys); #1;
    checks++;
    if (cart_rd !== 1'b0 || cart_wr !== 1'b0 || busy !== 1'b0 || cart_tran_bank1_dir !== 1'b0 ||
        cart_address !== 16'h0000 || bridge_8bit_rd_data !== 8'h00)
      $display("FAIL reset_mid abort: got rd=%b wr=%b busy=%b dir=%b addr=%h rd_data=%h required all zero",
               cart_rd, cart_wr, busy, cart_tran_bank1_dir, cart_address, bridge_8bit_rd_data);
    else passes++;
    reset = 1'b0;
    m_bv = 0;
    exp_rd = 8'h00;
    repeat (30) @(negedge clk_sys);
    checks++;
    if (busy !== 1'b0 || bridge_8bit_rd_data !== 8'h00)
      $display("FAIL reset_mid no_completion: got busy=%b rd_data=%h required 0/00", busy, bridge_8bit_rd_data);
    else passes++;
  endtask

  initial begin
    test_reset();
    test_transactions(1'b1, 30);
    test_pending();
    test_reset_mid();
    test_transactions(1'b0, 8);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
